// File: rtl/m16_pkg.sv
// Shared constants and types for the telemetry slot scheduler.
package m16_pkg;

  localparam logic [11:0] FILL_DEFAULT = 12'hFFF;

  localparam logic [1:0] SRC_FAST = 2'd0;
  localparam logic [1:0] SRC_SLOW = 2'd1;
  localparam logic [1:0] SRC_FILL = 2'd2;

  localparam int unsigned SLOT_CNT_W = 5;

  typedef enum logic {StSync, StRun} schedState_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with the head word readable combinationally.
module sync_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wPtrQ, wPtrD, rPtrQ, rPtrD;
  logic [AW:0]      levelQ, levelD;
  logic             doPush, doPop;

  assign empty = (levelQ == '0);
  assign full  = (levelQ == (AW+1)'(DEPTH));
  assign level = levelQ;
  assign rData = mem[rPtrQ];

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  always_comb begin
    wPtrD  = wPtrQ;
    rPtrD  = rPtrQ;
    levelD = levelQ;
    if (doPush) wPtrD = wPtrQ + 1'b1;
    if (doPop)  rPtrD = rPtrQ + 1'b1;
    unique case ({doPush, doPop})
      2'b10:   levelD = levelQ + 1'b1;
      2'b01:   levelD = levelQ - 1'b1;
      default: levelD = levelQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wPtrQ  <= '0;
      rPtrQ  <= '0;
      levelQ <= '0;
    end else begin
      wPtrQ  <= wPtrD;
      rPtrQ  <= rPtrD;
      levelQ <= levelD;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wPtrQ] <= wData;
  end

endmodule

// File: rtl/slot_scheduler.sv
// Frames fast and slow telemetry words into fixed slots, one slot per transmitter request.
module slot_scheduler
  import m16_pkg::*;
#(
  parameter int unsigned FAST_DEPTH = 16,
  parameter int unsigned SLOTS      = 17,
  parameter logic [11:0] FILL       = FILL_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frameStart,
  input  logic [11:0]                   fData,
  input  logic                          fVal,
  input  logic [11:0]                   sData,
  input  logic                          sVal,
  input  logic                          slotReq,
  output logic [11:0]                   oData,
  output logic                          oVal,
  output logic [1:0]                    oSrc,
  output logic [SLOT_CNT_W-1:0]         slotCnt,
  output logic [$clog2(FAST_DEPTH):0]   fLevel,
  output logic                          fOvf,
  output logic                          sOvf
);

  schedState_t            stateQ, stateD;
  logic [SLOT_CNT_W-1:0]  slotCntQ, slotCntD, slotIdx;
  logic [11:0]            oDataQ, oDataD, sHoldQ, sHoldD;
  logic [1:0]             oSrcQ, oSrcD;
  logic                   oValQ, oValD, sFullQ, sFullD;
  logic                   fOvfQ, fOvfD, sOvfQ, sOvfD;
  logic                   serve, isSlow, fPop, sRead;
  logic [11:0]            fHead;
  logic                   fFull, fEmpty;

  sync_fifo #(
    .WIDTH (12),
    .DEPTH (FAST_DEPTH)
  ) uFastFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fVal),
    .wData (fData),
    .pop   (fPop),
    .rData (fHead),
    .full  (fFull),
    .empty (fEmpty),
    .level (fLevel)
  );

  // A frameStart arriving with a request realigns first, so the request lands in slot 0.
  assign serve   = slotReq && (stateQ == StRun);
  assign slotIdx = frameStart ? '0 : slotCntQ;
  assign isSlow  = (slotIdx == SLOT_CNT_W'(SLOTS - 1));
  assign fPop    = serve && !isSlow && !fEmpty;
  assign sRead   = serve && isSlow && sFullQ;

  always_comb begin
    stateD   = stateQ;
    slotCntD = slotCntQ;
    oDataD   = oDataQ;
    oSrcD    = oSrcQ;
    oValD    = 1'b0;
    sHoldD   = sHoldQ;
    sFullD   = sFullQ;
    fOvfD    = fOvfQ;
    sOvfD    = sOvfQ;

    if (frameStart) begin
      stateD   = StRun;
      slotCntD = '0;
      fOvfD    = 1'b0;
      sOvfD    = 1'b0;
    end

    if (serve) begin
      oValD    = 1'b1;
      slotCntD = isSlow ? '0 : slotIdx + 1'b1;
      if (fPop) begin
        oDataD = fHead;
        oSrcD  = SRC_FAST;
      end else if (sRead) begin
        oDataD = sHoldQ;
        oSrcD  = SRC_SLOW;
      end else begin
        oDataD = FILL;
        oSrcD  = SRC_FILL;
      end
    end

    if (sRead) sFullD = 1'b0;
    // A new slow word during its own slot read keeps the hold full without an overflow.
    if (sVal) begin
      sHoldD = sData;
      sFullD = 1'b1;
      if (sFullQ && !sRead) sOvfD = 1'b1;
    end

    if (fVal && fFull && !fPop) fOvfD = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ   <= StSync;
      slotCntQ <= '0;
      oDataQ   <= '0;
      oSrcQ    <= '0;
      oValQ    <= 1'b0;
      sHoldQ   <= '0;
      sFullQ   <= 1'b0;
      fOvfQ    <= 1'b0;
      sOvfQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      slotCntQ <= slotCntD;
      oDataQ   <= oDataD;
      oSrcQ    <= oSrcD;
      oValQ    <= oValD;
      sHoldQ   <= sHoldD;
      sFullQ   <= sFullD;
      fOvfQ    <= fOvfD;
      sOvfQ    <= sOvfD;
    end
  end

  assign oData   = oDataQ;
  assign oSrc    = oSrcQ;
  assign oVal    = oValQ;
  assign slotCnt = slotCntQ;
  assign fOvf    = fOvfQ;
  assign sOvf    = sOvfQ;

endmodule

// File: tb/tb_slot_scheduler.sv
// Directed vector bench for slot_scheduler with default parameters.
module tb_slot_scheduler;
  import m16_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frameStart = 1'b0, fVal = 1'b0, sVal = 1'b0, slotReq = 1'b0;
  logic [11:0] fData = '0, sData = '0;
  logic [11:0] oData;
  logic        oVal;
  logic [1:0]  oSrc;
  logic [4:0]  slotCnt;
  logic [4:0]  fLevel;
  logic        fOvf, sOvf;

  slot_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .frameStart (frameStart),
    .fData      (fData),
    .fVal       (fVal),
    .sData      (sData),
    .sVal       (sVal),
    .slotReq    (slotReq),
    .oData      (oData),
    .oVal       (oVal),
    .oSrc       (oSrc),
    .slotCnt    (slotCnt),
    .fLevel     (fLevel),
    .fOvf       (fOvf),
    .sOvf       (sOvf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fs, fv, sv, rq;
    logic [11:0] fd, sd;
    logic        eVal;
    logic [11:0] eData;
    logic [1:0]  eSrc;
    logic [4:0]  eCnt, eLvl;
    logic        eFo, eSo;
  } vec_t;

  vec_t vecs[$];
  int   nVec = 0;
  int   nFail = 0;

  // Expected output state after the vector being added.
  logic [11:0] eData = '0;
  logic [1:0]  eSrc = '0;
  logic [4:0]  eCnt = '0, eLvl = '0;
  logic        eFo = 1'b0, eSo = 1'b0;

  function automatic void add(input logic fs, input logic fv, input logic [11:0] fd,
                              input logic sv, input logic [11:0] sd, input logic rq,
                              input logic ev);
    vec_t v;
    v.fs = fs; v.fv = fv; v.fd = fd; v.sv = sv; v.sd = sd; v.rq = rq;
    v.eVal = ev; v.eData = eData; v.eSrc = eSrc; v.eCnt = eCnt; v.eLvl = eLvl;
    v.eFo = eFo; v.eSo = eSo;
    vecs.push_back(v);
  endfunction

  function automatic void idle();
    add(1'b0, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0, 1'b0);
  endfunction

  // One request plus the mandatory gap cycle in which the word is held.
  function automatic void serve(input logic [11:0] d, input logic [1:0] s, input int c);
    eData = d; eSrc = s; eCnt = 5'(c);
    add(1'b0, 1'b0, 12'h0, 1'b0, 12'h0, 1'b1, 1'b1);
    idle();
  endfunction

  task automatic check(input vec_t v, input string name);
    nVec++;
    if (oVal !== v.eVal || oData !== v.eData || oSrc !== v.eSrc || slotCnt !== v.eCnt ||
        fLevel !== v.eLvl || fOvf !== v.eFo || sOvf !== v.eSo) begin
      nFail++;
      $display("FAIL %s: got oVal=%0b oData=%h oSrc=%0d slotCnt=%0d fLevel=%0d fOvf=%0b sOvf=%0b, want oVal=%0b oData=%h oSrc=%0d slotCnt=%0d fLevel=%0d fOvf=%0b sOvf=%0b",
               name, oVal, oData, oSrc, slotCnt, fLevel, fOvf, sOvf,
               v.eVal, v.eData, v.eSrc, v.eCnt, v.eLvl, v.eFo, v.eSo);
    end
  endtask

  task automatic applyAll(input string tag);
    foreach (vecs[i]) begin
      @(negedge clk);
      frameStart = vecs[i].fs; fVal = vecs[i].fv; fData = vecs[i].fd;
      sVal = vecs[i].sv; sData = vecs[i].sd; slotReq = vecs[i].rq;
      @(posedge clk);
      #1;
      check(vecs[i], $sformatf("%s%0d", tag, i));
    end
    @(negedge clk);
    frameStart = 1'b0; fVal = 1'b0; sVal = 1'b0; slotReq = 1'b0;
  endtask

  initial begin
    vec_t z;

    // Reset state, then requests before any frameStart are ignored.
    idle();
    for (int i = 0; i < 3; i++) begin
      add(1'b0, 1'b0, 12'h0, 1'b0, 12'h0, 1'b1, 1'b0);
      idle();
    end
    add(1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0, 1'b0);

    // Full frame: 16 fast words plus one slow word.
    for (int i = 0; i < 16; i++) begin
      eLvl = 5'(i + 1);
      add(1'b0, 1'b1, 12'(12'h010 + i), 1'b0, 12'h0, 1'b0, 1'b0);
    end
    add(1'b0, 1'b0, 12'h0, 1'b1, 12'h5A4, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      eLvl = 5'(15 - k);
      serve(12'(12'h010 + k), SRC_FAST, k + 1);
    end
    serve(12'h5A4, SRC_SLOW, 0);

    // Empty frame: all fill.
    for (int k = 0; k < 17; k++) serve(12'hFFF, SRC_FILL, (k + 1) % 17);

    // Fast overflow: 17th word dropped, first 16 drained in order.
    for (int i = 0; i < 17; i++) begin
      if (i < 16) eLvl = 5'(i + 1);
      else eFo = 1'b1;
      add(1'b0, 1'b1, 12'(12'h100 + i), 1'b0, 12'h0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 16; k++) begin
      eLvl = 5'(15 - k);
      serve(12'(12'h100 + k), SRC_FAST, k + 1);
    end
    serve(12'hFFF, SRC_FILL, 0);
    eFo = 1'b0;
    add(1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0, 1'b0);

    // Slow overwrite, then a new slow word arriving during the slow slot read.
    add(1'b0, 1'b0, 12'h0, 1'b1, 12'h111, 1'b0, 1'b0);
    eSo = 1'b1;
    add(1'b0, 1'b0, 12'h0, 1'b1, 12'h222, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) serve(12'hFFF, SRC_FILL, k + 1);
    eData = 12'h222; eSrc = SRC_SLOW; eCnt = 5'd0;
    add(1'b0, 1'b0, 12'h0, 1'b1, 12'h777, 1'b1, 1'b1);
    idle();
    eSo = 1'b0;
    add(1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) serve(12'hFFF, SRC_FILL, k + 1);
    serve(12'h777, SRC_SLOW, 0);

    // frameStart with slotReq at slotCnt=9, word written the cycle before.
    for (int k = 0; k < 9; k++) serve(12'hFFF, SRC_FILL, k + 1);
    eLvl = 5'd1;
    add(1'b0, 1'b1, 12'h333, 1'b0, 12'h0, 1'b0, 1'b0);
    eLvl = 5'd0; eData = 12'h333; eSrc = SRC_FAST; eCnt = 5'd1;
    add(1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 1'b1, 1'b1);
    idle();

    // Overflow in the same cycle as frameStart: set wins.
    for (int i = 0; i < 16; i++) begin
      eLvl = 5'(i + 1);
      add(1'b0, 1'b1, 12'(12'h400 + i), 1'b0, 12'h0, 1'b0, 1'b0);
    end
    eFo = 1'b1; eCnt = 5'd0;
    add(1'b1, 1'b1, 12'h4FF, 1'b0, 12'h0, 1'b0, 1'b0);
    eLvl = 5'd15;
    serve(12'h400, SRC_FAST, 1);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyAll("vec");

    // Asynchronous reset mid-frame clears outputs without waiting for a clock edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    z.fs = 0; z.fv = 0; z.sv = 0; z.rq = 0; z.fd = 0; z.sd = 0;
    z.eVal = 0; z.eData = 0; z.eSrc = 0; z.eCnt = 0; z.eLvl = 0; z.eFo = 0; z.eSo = 0;
    check(z, "asyncRst");
    @(negedge clk);
    rst = 1'b0;

    // Back in SYNC: requests ignored, including one coinciding with frameStart.
    vecs.delete();
    eData = '0; eSrc = '0; eCnt = '0; eLvl = '0; eFo = 1'b0; eSo = 1'b0;
    add(1'b0, 1'b0, 12'h0, 1'b0, 12'h0, 1'b1, 1'b0);
    idle();
    add(1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 1'b1, 1'b0);
    idle();
    serve(12'hFFF, SRC_FILL, 1);
    applyAll("post");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
